// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction-fetch stage: PC, IF/ID register, stall/flush/redirect, misaligned-target fault
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instruction,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_instruction,
    output logic [31:0]     fetch_count,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_pc4_q, if_pc4_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [XLEN-1:0] pc_next_seq;

    assign pc_next_seq = pc_q + FOUR;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        if_pc_d       = if_pc_q;
        if_pc4_d      = if_pc4_q;
        if_instr_d    = if_instr_q;
        fetch_count_d = fetch_count_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
                    pc_d       = redirect_pc;
                    valid_d    = 1'b0;
                    if_instr_d = '0;
                end else if (redirect_valid) begin
                    // Misaligned target: freeze fetch and park here until reset
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc;
                    valid_d    = 1'b0;
                    if_instr_d = '0;
                end else if (flush) begin
                    valid_d    = 1'b0;
                    if_instr_d = '0;
                    if (!stall) pc_d = pc_next_seq;
                end else if (!stall) begin
                    valid_d       = 1'b1;
                    if_pc_d       = pc_q;
                    if_pc4_d      = pc_next_seq;
                    if_instr_d    = instruction;
                    pc_d          = pc_next_seq;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            FAULT: begin
                valid_d    = 1'b0;
                if_instr_d = '0;
            end
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            valid_q       <= 1'b0;
            if_pc_q       <= '0;
            if_pc4_q      <= '0;
            if_instr_q    <= '0;
            fetch_count_q <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            if_pc_q       <= if_pc_d;
            if_pc4_q      <= if_pc4_d;
            if_instr_q    <= if_instr_d;
            fetch_count_q <= fetch_count_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign pc                = pc_q;
    assign if_id_valid       = valid_q;
    assign if_id_pc          = if_pc_q;
    assign if_id_pc_plus4    = if_pc4_q;
    assign if_id_instruction = if_instr_q;
    assign fetch_count       = fetch_count_q;
    assign fault             = fault_q;
    assign fault_pc          = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Self-checking bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic [31:0] fetch_count;
    logic        fault;
    logic [31:0] fault_pc;

    int checks;
    int failures;

    logic [31:0] mem [0:63];

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pc                (pc),
        .instruction       (instruction),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction),
        .fetch_count       (fetch_count),
        .fault             (fault),
        .fault_pc          (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return a ^ 32'h5A5A_A5A5;
    endfunction

    always_comb instruction = mem_word(pc);

    // Behavioural model: architectural state of the fetch stage
    logic        m_boot, m_faulted;
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_count, m_fpc;
    logic        m_valid, m_fault;

    task automatic model_reset();
        m_boot = 1'b1; m_faulted = 1'b0;
        m_pc = 32'h0; m_valid = 1'b0; m_ifpc = 0; m_ifpc4 = 0; m_instr = 0;
        m_count = 0; m_fault = 1'b0; m_fpc = 0;
    endtask

    task automatic model_step();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_faulted) begin
            m_valid = 1'b0;
        end else if (redirect_valid && (redirect_pc % 4 == 0)) begin
            m_pc = redirect_pc; m_valid = 1'b0; m_instr = 0;
        end else if (redirect_valid) begin
            m_faulted = 1'b1; m_fault = 1'b1; m_fpc = redirect_pc;
            m_valid = 1'b0; m_instr = 0;
        end else if (flush) begin
            m_valid = 1'b0; m_instr = 0;
            if (!stall) m_pc = m_pc + 4;
        end else if (!stall) begin
            m_valid = 1'b1; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
            m_instr = mem_word(m_pc); m_pc = m_pc + 4; m_count = m_count + 1;
        end
    endtask

    task automatic tick(input logic s, input logic f, input logic rv, input logic [31:0] rp);
        stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 0 || if_id_pc_plus4 !== 0 ||
            if_id_instruction !== 0 || fetch_count !== 0 || fault !== 1'b0 || fault_pc !== 0) begin
            failures++;
            $display("FAIL reset_state pc=%h v=%b ifpc=%h p4=%h ins=%h cnt=%0d f=%b fpc=%h required all zero",
                     pc, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction, fetch_count, fault, fault_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_boot_fetch();
        logic [31:0] exp_pc [0:3];
        exp_pc[0] = 32'd0; exp_pc[1] = 32'd4; exp_pc[2] = 32'd8; exp_pc[3] = 32'd12;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (pc !== exp_pc[i]) begin
                failures++;
                $display("FAIL boot_pc edge=%0d got=%h required=%h", i, pc, exp_pc[i]);
            end
            if (i == 0) begin
                checks++;
                if (if_id_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL boot_invalid got=%b required=0", if_id_valid);
                end
            end else begin
                checks++;
                if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc[i-1] || if_id_instruction !== mem[i-1]) begin
                    failures++;
                    $display("FAIL boot_ifid edge=%0d got v=%b pc=%h ins=%h required v=1 pc=%h ins=%h",
                             i, if_id_valid, if_id_pc, if_id_instruction, exp_pc[i-1], mem[i-1]);
                end
            end
        end
        checks++;
        if (fetch_count !== 32'd3) begin
            failures++;
            $display("FAIL boot_count got=%0d required=3", fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (pc !== 32'd8 || if_id_valid !== 1'b1 || if_id_pc !== 32'd4 ||
                if_id_instruction !== mem[1] || fetch_count !== 32'd2) begin
                failures++;
                $display("FAIL stall_hold pc=%h v=%b ifpc=%h ins=%h cnt=%0d required pc=8 v=1 ifpc=4 ins=%h cnt=2",
                         pc, if_id_valid, if_id_pc, if_id_instruction, fetch_count, mem[1]);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (if_id_pc !== 32'd8 || if_id_instruction !== mem[2] || pc !== 32'd12 || fetch_count !== 32'd3) begin
            failures++;
            $display("FAIL stall_release ifpc=%h ins=%h pc=%h cnt=%0d required ifpc=8 ins=%h pc=c cnt=3",
                     if_id_pc, if_id_instruction, pc, fetch_count, mem[2]);
        end
    endtask

    task automatic test_redirect();
        tick(1'b1, 1'b1, 1'b1, 32'h40);
        checks++;
        if (pc !== 32'h40 || if_id_valid !== 1'b0 || if_id_instruction !== 32'h0) begin
            failures++;
            $display("FAIL redirect_bubble pc=%h v=%b ins=%h required pc=40 v=0 ins=0",
                     pc, if_id_valid, if_id_instruction);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instruction !== mem[16] ||
            if_id_pc_plus4 !== 32'h44) begin
            failures++;
            $display("FAIL redirect_target v=%b ifpc=%h ins=%h p4=%h required v=1 ifpc=40 ins=%h p4=44",
                     if_id_valid, if_id_pc, if_id_instruction, if_id_pc_plus4, mem[16]);
        end
    endtask

    task automatic test_fault();
        logic [31:0] frozen_pc, frozen_cnt;
        frozen_pc  = pc;
        frozen_cnt = m_count;
        tick(1'b0, 1'b0, 1'b1, 32'h42);
        checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h42 || pc !== frozen_pc || if_id_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_entry f=%b fpc=%h pc=%h v=%b required f=1 fpc=42 pc=%h v=0",
                     fault, fault_pc, pc, if_id_valid, frozen_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, $urandom & 32'hFF);
            checks++;
            if (fault !== 1'b1 || fault_pc !== 32'h42 || pc !== frozen_pc || if_id_valid !== 1'b0 ||
                fetch_count !== frozen_cnt) begin
                failures++;
                $display("FAIL fault_sticky edge=%0d f=%b fpc=%h pc=%h v=%b cnt=%0d required f=1 fpc=42 pc=%h v=0 cnt=%0d",
                         i, fault, fault_pc, pc, if_id_valid, fetch_count, frozen_pc, frozen_cnt);
            end
        end
        do_reset();
        checks++;
        if (fault !== 1'b0 || fault_pc !== 32'h0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL fault_clear f=%b fpc=%h pc=%h required f=0 fpc=0 pc=0", fault, fault_pc, pc);
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap ifpc=%h p4=%h pc=%h required ifpc=fffffffc p4=0 pc=0",
                     if_id_pc, if_id_pc_plus4, pc);
        end
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        m_count = 32'hFFFF_FFFE;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (fetch_count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL count_max got=%h required=ffffffff", fetch_count);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (fetch_count !== 32'h0) begin
            failures++;
            $display("FAIL count_wrap got=%h required=0", fetch_count);
        end
    endtask

    task automatic test_flush();
        tick(1'b0, 1'b0, 1'b1, 32'd20);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (if_id_valid !== 1'b0 || pc !== 32'd24 || if_id_instruction !== 32'h0) begin
            failures++;
            $display("FAIL flush_nostall v=%b pc=%h ins=%h required v=0 pc=18 ins=0",
                     if_id_valid, pc, if_id_instruction);
        end
        tick(1'b0, 1'b0, 1'b1, 32'd20);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (if_id_valid !== 1'b0 || pc !== 32'd24) begin
            failures++;
            $display("FAIL flush_stall v=%b pc=%h required v=0 pc=18", if_id_valid, pc);
        end
        tick(1'b0, 1'b0, 1'b1, 32'd20);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (if_id_valid !== 1'b0 || pc !== 32'd20) begin
            failures++;
            $display("FAIL flush_stall_hold v=%b pc=%h required v=0 pc=14", if_id_valid, pc);
        end
    endtask

    task automatic test_random();
        logic        s, f, rv;
        logic [31:0] rp;
        for (int i = 0; i < 400; i++) begin
            if (m_faulted && $urandom_range(0, 7) == 0) do_reset();
            s  = $urandom_range(0, 3) == 0;
            f  = $urandom_range(0, 7) == 0;
            rv = $urandom_range(0, 9) == 0;
            rp = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFF) : ($urandom & 32'hFC);
            tick(s, f, rv, rp);
            checks++;
            if (pc !== m_pc || if_id_valid !== m_valid || if_id_pc !== m_ifpc || if_id_pc_plus4 !== m_ifpc4 ||
                if_id_instruction !== m_instr || fetch_count !== m_count || fault !== m_fault ||
                fault_pc !== m_fpc) begin
                failures++;
                $display("FAIL random_step %0d got pc=%h v=%b ifpc=%h p4=%h ins=%h cnt=%0d f=%b fpc=%h required pc=%h v=%b ifpc=%h p4=%h ins=%h cnt=%0d f=%b fpc=%h",
                         i, pc, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction, fetch_count, fault, fault_pc,
                         m_pc, m_valid, m_ifpc, m_ifpc4, m_instr, m_count, m_fault, m_fpc);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_boot_fetch();
        test_stall();
        test_redirect();
        test_fault();
        test_wrap();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
